// File: rtl/mips_defs.sv
// mips_defs: shared definitions for the P6 fetch path.
//   - npc_sel encodings driven by the ID-stage control
//   - reset PC, instruction-memory window, nop encoding
//   - pc_fault(): fetch-address legality check (alignment + window)
package mips_defs;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_DEPTH = 4096;
    localparam logic [31:0] IM_LAST  = IM_BASE + 32'(4 * IM_DEPTH) - 32'd4;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // A fetch is faulty if the word address is misaligned or falls
    // outside the instruction-memory window.
    function automatic logic pc_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC selection.
//   pc        : current fetch PC (sequential fall-through)
//   id_pc     : PC of the branch/jump sitting in ID (target base)
//   npc_sel   : NPC_SEQ / NPC_BR / NPC_J / NPC_JR
//   br_taken  : ID comparator result, used only for NPC_BR
//   imm16     : branch offset in words, sign-extended
//   index26   : jump index
//   rs_val    : forwarded register target for jr/jalr
//   next_pc   : PC to load on the next unstalled edge
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] id_pc,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_val,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc_plus4  = pc + 32'd4;
    // Branch offset is relative to the delay slot (id_pc+4); wraps mod 2^32.
    assign br_target = id_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    // Region bits come from the jump's own PC, not from the fetch PC.
    assign j_target  = {id_pc[31:28], index26, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel_e'(npc_sel))
            NPC_SEQ: next_pc = pc_plus4;
            NPC_BR:  next_pc = br_taken ? br_target : pc_plus4;
            NPC_J:   next_pc = j_target;
            NPC_JR:  next_pc = rs_val;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC register and IF/ID register.
//   clk, reset_n        : clock, async active-low reset
//   stall               : freezes PC and IF/ID
//   npc_sel, br_taken,
//   id_imm16, id_index26,
//   id_rs_val           : redirect request from ID
//   im_addr / im_rdata  : combinational instruction-memory port
//   id_instr, id_pc,
//   id_pc8, id_fetch_err: IF/ID register outputs
// Redirects never flush: the word fetched while a redirect resolves in ID
// is the delay slot and is latched as usual.
module if_stage
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_index26,
    input  logic [31:0] id_rs_val,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_fetch_err
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        fetch_err;

    npc_calc u_npc_calc (
        .pc       (pc),
        .id_pc    (id_pc),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .imm16    (id_imm16),
        .index26  (id_index26),
        .rs_val   (id_rs_val),
        .next_pc  (next_pc)
    );

    assign fetch_err = pc_fault(pc);
    assign im_addr   = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc           <= PC_RESET;
            id_instr     <= NOP;
            id_pc        <= PC_RESET;
            id_pc8       <= PC_RESET + 32'd8;
            id_fetch_err <= 1'b0;
        end else if (!stall) begin
            pc           <= next_pc;
            // A faulty fetch hands a nop to decode; the flag carries the fault.
            id_instr     <= fetch_err ? NOP : im_rdata;
            id_pc        <= pc;
            id_pc8       <= pc + 32'd8;
            id_fetch_err <= fetch_err;
        end
    end

endmodule
